mac_pe: RTL and testbench

- Parametrised systolic processing element; next generation of the 8-bit load/mult/acc MAC cell used in the matrix-multiply array.
- Operands stream in with valid/first/last framing. Each operand is forwarded one cycle later to the east (a) and south (b) neighbours.
- A 2-stage multiply/accumulate pipeline computes one dot product per first..last group.
- The finished sum is held in a result register with a valid/ready handshake, so the array controller can drain it without stalling the stream.

---
 rtl/mac_pe.sv | 226 ++++++++++++++++++++++
 tb/tb_mac_pe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pe.sv
// mac_pe: systolic multiply/accumulate processing element.
// Operands are forwarded east/south with one cycle of latency. A two-stage
// pipeline (multiply, then accumulate) produces one dot product per
// first..last group. The sum is parked in a result register with a
// valid/ready handshake.
// Optional build macro: MAC_PE_SATURATE_EN (saturating accumulate + sat_hit).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no group open; the next valid sample starts a new group
// ACCUM | group open; samples add to acc until one carries last
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              valid_in,
  input  logic              first_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic              first_out,
  output logic              last_out,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              proto_err,
  output logic              overrun,
  output logic              sat_hit
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W - PROD_W;

  if (ACC_W < 2 * DATA_W) begin : g_width_check
    $error("mac_pe: ACC_W must be at least 2*DATA_W");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic              valid_out_q, valid_out_d;
  logic              first_out_q, first_out_d;
  logic              last_out_q, last_out_d;

  logic [PROD_W-1:0] p1_q, p1_d;
  logic              v1_q, v1_d, f1_q, f1_d, l1_q, l1_d;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              proto_err_q, proto_err_d;
  logic              overrun_q, overrun_d;
  logic              sat_hit_q, sat_hit_d;

  logic [PROD_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]  ext_p1, base, sum;
  logic              start_grp, frame_err, sat;

  // Operand extension to product width; sign extension makes the low
  // PROD_W bits of the product equal the two's complement product.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = {{DATA_W{a_in[DATA_W-1]}}, a_in};
      b_ext = {{DATA_W{b_in[DATA_W-1]}}, b_in};
    end else begin
      a_ext = {{DATA_W{1'b0}}, a_in};
      b_ext = {{DATA_W{1'b0}}, b_in};
    end
    prod = a_ext * b_ext;
  end

  if (EXT_W == 0) begin : g_ext_none
    assign ext_p1 = p1_q;
  end else begin : g_ext
    assign ext_p1 = {{EXT_W{(SIGNED != 0) & p1_q[PROD_W-1]}}, p1_q};
  end

  // Forwarding and stage-1 capture; no stall path.
  always_comb begin
    a_out_d     = a_in;
    b_out_d     = b_in;
    valid_out_d = valid_in;
    first_out_d = first_in;
    last_out_d  = last_in;
    v1_d        = valid_in;
    f1_d        = valid_in & first_in;
    l1_d        = valid_in & last_in;
    p1_d        = valid_in ? prod : p1_q;
  end

  // Group FSM: decides whether this sample starts a fresh sum and flags bad framing.
  always_comb begin
    state_d   = state_q;
    start_grp = 1'b0;
    frame_err = 1'b0;
    if (v1_q) begin
      case (state_q)
        IDLE: begin
          start_grp = 1'b1;
          frame_err = ~f1_q;
        end
        ACCUM: begin
          start_grp = f1_q;
          frame_err = f1_q;
        end
        default: ;
      endcase
      state_d = l1_q ? IDLE : ACCUM;
    end
  end

  assign base = start_grp ? '0 : acc_q;

`ifdef MAC_PE_SATURATE_EN
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] sum_wrap;
  logic             ovf;

  // Saturating add: clamp toward the sign of the operands on overflow.
  always_comb begin
    sum_full = {1'b0, base} + {1'b0, ext_p1};
    sum_wrap = sum_full[ACC_W-1:0];
    if (SIGNED != 0) begin
      ovf = (base[ACC_W-1] == ext_p1[ACC_W-1]) && (sum_wrap[ACC_W-1] != base[ACC_W-1]);
      sum = ovf ? {base[ACC_W-1], {(ACC_W-1){~base[ACC_W-1]}}} : sum_wrap;
    end else begin
      ovf = sum_full[ACC_W];
      sum = ovf ? '1 : sum_wrap;
    end
    sat = ovf;
  end
`else
  // Wrapping add.
  always_comb begin
    sum = base + ext_p1;
    sat = 1'b0;
  end
`endif

  // Accumulator, result handshake and sticky status flags.
  always_comb begin
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;
    proto_err_d    = proto_err_q | frame_err;
    sat_hit_d      = sat_hit_q | (v1_q & sat);
    if (v1_q) begin
      acc_d = sum;
    end
    if (v1_q && l1_q) begin
      if (!result_valid_q || result_ready) begin
        result_d       = sum;
        result_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  // All state registers; async reset discards pipeline contents and partial sums.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      a_out_q        <= '0;
      b_out_q        <= '0;
      valid_out_q    <= 1'b0;
      first_out_q    <= 1'b0;
      last_out_q     <= 1'b0;
      p1_q           <= '0;
      v1_q           <= 1'b0;
      f1_q           <= 1'b0;
      l1_q           <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      proto_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
      sat_hit_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_out_q        <= a_out_d;
      b_out_q        <= b_out_d;
      valid_out_q    <= valid_out_d;
      first_out_q    <= first_out_d;
      last_out_q     <= last_out_d;
      p1_q           <= p1_d;
      v1_q           <= v1_d;
      f1_q           <= f1_d;
      l1_q           <= l1_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      proto_err_q    <= proto_err_d;
      overrun_q      <= overrun_d;
      sat_hit_q      <= sat_hit_d;
    end
  end

  assign a_out        = a_out_q;
  assign b_out        = b_out_q;
  assign valid_out    = valid_out_q;
  assign first_out    = first_out_q;
  assign last_out     = last_out_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q == ACCUM);
  assign proto_err    = proto_err_q;
  assign overrun      = overrun_q;
  assign sat_hit      = sat_hit_q;

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: three instances (32-bit unsigned, 32-bit signed,
// 16-bit unsigned) share one stimulus stream. A group-level arithmetic
// model predicts every output each cycle; directed literals pin the model.
module tb_mac_pe;

  localparam int NC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_in, b_in;
  logic       valid_in, first_in, last_in, result_ready;

  logic [7:0]  a_out [NC];
  logic [7:0]  b_out [NC];
  logic        valid_out [NC], first_out [NC], last_out [NC];
  logic        rv [NC], busy [NC], perr [NC], ovr [NC], sat [NC];
  logic [31:0] res0, res1;
  logic [15:0] res2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mac_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(0)) dut0 (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
    .first_in(first_in), .last_in(last_in), .a_out(a_out[0]), .b_out(b_out[0]),
    .valid_out(valid_out[0]), .first_out(first_out[0]), .last_out(last_out[0]),
    .result(res0), .result_valid(rv[0]), .result_ready(result_ready),
    .busy(busy[0]), .proto_err(perr[0]), .overrun(ovr[0]), .sat_hit(sat[0]));

  mac_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(1)) dut1 (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
    .first_in(first_in), .last_in(last_in), .a_out(a_out[1]), .b_out(b_out[1]),
    .valid_out(valid_out[1]), .first_out(first_out[1]), .last_out(last_out[1]),
    .result(res1), .result_valid(rv[1]), .result_ready(result_ready),
    .busy(busy[1]), .proto_err(perr[1]), .overrun(ovr[1]), .sat_hit(sat[1]));

  mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(0)) dut2 (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
    .first_in(first_in), .last_in(last_in), .a_out(a_out[2]), .b_out(b_out[2]),
    .valid_out(valid_out[2]), .first_out(first_out[2]), .last_out(last_out[2]),
    .result(res2), .result_valid(rv[2]), .result_ready(result_ready),
    .busy(busy[2]), .proto_err(perr[2]), .overrun(ovr[2]), .sat_hit(sat[2]));

  // ---------------- reference model ----------------
  int     accw [NC] = '{32, 32, 16};
  bit     sgn  [NC] = '{1'b0, 1'b1, 1'b0};

  longint acc_m [NC], res_m [NC];
  bit     rv_m [NC], ovr_m [NC], sat_m [NC];
  bit     perr_m, ingrp_m;
  bit     s1v, s1f, s1l;
  logic [7:0] s1a, s1b;
  logic [7:0] fa, fb;
  bit     fv, ff, fl;
  longint m_sum, m_hi, m_lo;
  bit     m_start;

  function automatic longint opval(int c, logic [7:0] x);
    if (sgn[c]) return longint'($signed(x));
    return longint'({56'b0, x});
  endfunction

  function automatic longint acc_num(int c, longint bits);
    if (sgn[c] && bits[accw[c]-1]) return bits - (64'sd1 <<< accw[c]);
    return bits;
  endfunction

  function automatic logic [63:0] get_res(int c);
    if (c == 0) return {32'b0, res0};
    if (c == 1) return {32'b0, res1};
    return {48'b0, res2};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        acc_m[c] = 0; res_m[c] = 0; rv_m[c] = 0; ovr_m[c] = 0; sat_m[c] = 0;
      end
      perr_m = 0; ingrp_m = 0;
      s1v = 0; s1f = 0; s1l = 0; s1a = 0; s1b = 0;
      fa = 0; fb = 0; fv = 0; ff = 0; fl = 0;
    end else begin
      if (s1v) begin
        m_start = !ingrp_m || s1f;
        if (ingrp_m == s1f) perr_m = 1;
        for (int c = 0; c < NC; c++) begin
          m_sum = (m_start ? 64'sd0 : acc_num(c, acc_m[c])) + opval(c, s1a) * opval(c, s1b);
`ifdef MAC_PE_SATURATE_EN
          m_hi = sgn[c] ? (64'sd1 <<< (accw[c]-1)) - 1 : (64'sd1 <<< accw[c]) - 1;
          m_lo = sgn[c] ? -(64'sd1 <<< (accw[c]-1)) : 64'sd0;
          if (m_sum > m_hi) begin m_sum = m_hi; sat_m[c] = 1; end
          if (m_sum < m_lo) begin m_sum = m_lo; sat_m[c] = 1; end
`endif
          acc_m[c] = m_sum & ((64'sd1 <<< accw[c]) - 1);
          if (s1l) begin
            if (!rv_m[c] || result_ready) begin
              res_m[c] = acc_m[c];
              rv_m[c]  = 1;
            end else begin
              ovr_m[c] = 1;
            end
          end
        end
        ingrp_m = !s1l;
      end
      if (!(s1v && s1l)) begin
        for (int c = 0; c < NC; c++)
          if (rv_m[c] && result_ready) rv_m[c] = 0;
      end
      s1v = valid_in; s1f = first_in; s1l = last_in; s1a = a_in; s1b = b_in;
      fa = a_in; fb = b_in; fv = valid_in; ff = first_in; fl = last_in;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("a_out", {56'b0, a_out[0]}, {56'b0, fa});
      chk("b_out", {56'b0, b_out[0]}, {56'b0, fb});
      chk("valid_out", {63'b0, valid_out[0]}, {63'b0, fv});
      chk("first_out", {63'b0, first_out[0]}, {63'b0, ff});
      chk("last_out", {63'b0, last_out[0]}, {63'b0, fl});
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("result[%0d]", c), get_res(c), res_m[c]);
        chk($sformatf("result_valid[%0d]", c), {63'b0, rv[c]}, {63'b0, rv_m[c]});
        chk($sformatf("busy[%0d]", c), {63'b0, busy[c]}, {63'b0, ingrp_m});
        chk($sformatf("proto_err[%0d]", c), {63'b0, perr[c]}, {63'b0, perr_m});
        chk($sformatf("overrun[%0d]", c), {63'b0, ovr[c]}, {63'b0, ovr_m[c]});
        chk($sformatf("sat_hit[%0d]", c), {63'b0, sat[c]}, {63'b0, sat_m[c]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [7:0] a, input logic [7:0] b, input logic v,
                     input logic f, input logic l);
    a_in = a; b_in = b; valid_in = v; first_in = f; last_in = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    result_ready = 1'b1;
    idle();
    result_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_in = 0; b_in = 0; valid_in = 0; first_in = 0; last_in = 0; result_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset result", {32'b0, res0}, 64'd0);
    chk("reset result_valid", {63'b0, rv[0]}, 64'd0);
    chk("reset a_out", {56'b0, a_out[0]}, 64'd0);
    chk("reset busy", {63'b0, busy[0]}, 64'd0);

    // Basic group: 5*10 + 5*10 + 3*4 = 112
    cyc(8'd5, 8'd10, 1, 1, 0);
    chk("fwd a_out 5", {56'b0, a_out[0]}, 64'd5);
    chk("fwd b_out 10", {56'b0, b_out[0]}, 64'd10);
    cyc(8'd5, 8'd10, 1, 0, 0);
    chk("busy in group", {63'b0, busy[0]}, 64'd1);
    cyc(8'd3, 8'd4, 1, 0, 1);
    chk("rv not yet", {63'b0, rv[0]}, 64'd0);
    idle();
    chk("sum 112", {32'b0, res0}, 64'd112);
    chk("rv after 2 edges", {63'b0, rv[0]}, 64'd1);
    drain();
    chk("rv drained", {63'b0, rv[0]}, 64'd0);

    // Signed vs unsigned interpretation of the same bytes
    cyc(8'hFD, 8'h07, 1, 1, 0);
    cyc(8'h02, 8'hF8, 1, 0, 1);
    idle();
    chk("signed -37", {32'b0, res1}, 64'hFFFF_FFDB);
    chk("unsigned 2267", {32'b0, res0}, 64'd2267);
    drain();

    // Back-to-back single-element groups, consumer ready
    result_ready = 1'b1;
    cyc(8'd6, 8'd6, 1, 1, 1);
    cyc(8'd2, 8'd9, 1, 1, 1);
    chk("b2b first 36", {32'b0, res0}, 64'd36);
    idle();
    chk("b2b second 18", {32'b0, res0}, 64'd18);
    chk("b2b rv", {63'b0, rv[0]}, 64'd1);
    idle();
    result_ready = 1'b0;
    // Same groups, consumer stalled: second sum is dropped
    cyc(8'd6, 8'd6, 1, 1, 1);
    cyc(8'd2, 8'd9, 1, 1, 1);
    idle();
    idle();
    chk("held 36", {32'b0, res0}, 64'd36);
    chk("overrun set", {63'b0, ovr[0]}, 64'd1);
    drain();

    // Valid without first from IDLE: 16 + 1 = 17
    cyc(8'd4, 8'd4, 1, 0, 0);
    cyc(8'd1, 8'd1, 1, 0, 1);
    idle();
    chk("no-first 17", {32'b0, res0}, 64'd17);
    chk("proto_err", {63'b0, perr[0]}, 64'd1);
    drain();
    // First mid-group restarts: 9 + 5 = 14
    cyc(8'd2, 8'd2, 1, 1, 0);
    cyc(8'd3, 8'd3, 1, 1, 0);
    cyc(8'd1, 8'd5, 1, 0, 1);
    idle();
    chk("restart 14", {32'b0, res0}, 64'd14);
    chk("proto_err sticky", {63'b0, perr[0]}, 64'd1);
    drain();

    // Async reset mid-group
    cyc(8'd7, 8'd7, 1, 1, 0);
    cyc(8'd1, 8'd1, 1, 0, 0);
    a_in = 0; b_in = 0; valid_in = 0; first_in = 0; last_in = 0;
    reset = 1'b1;
    #1;
    chk("rst busy", {63'b0, busy[0]}, 64'd0);
    chk("rst a_out", {56'b0, a_out[0]}, 64'd0);
    chk("rst result", {32'b0, res0}, 64'd0);
    chk("rst proto_err", {63'b0, perr[0]}, 64'd0);
    chk("rst overrun", {63'b0, ovr[0]}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(8'd2, 8'd3, 1, 1, 1);
    idle();
    chk("post-reset 6", {32'b0, res0}, 64'd6);
    drain();

    // 255*255 twice: overflows the 16-bit accumulator
    cyc(8'hFF, 8'hFF, 1, 1, 0);
    cyc(8'hFF, 8'hFF, 1, 0, 1);
    idle();
    chk("wide 130050", {32'b0, res0}, 64'd130050);
    chk("signed (-1)*(-1)*2", {32'b0, res1}, 64'd2);
`ifdef MAC_PE_SATURATE_EN
    chk("acc16 saturate", {48'b0, res2}, 64'hFFFF);
    chk("sat_hit", {63'b0, sat[2]}, 64'd1);
`else
    chk("acc16 wrap", {48'b0, res2}, 64'hFC02);
    chk("sat_hit tied", {63'b0, sat[2]}, 64'd0);
`endif
    drain();
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
